// File: rtl/fetch_controller_if.sv
// ---------------------------------------------------------------------------
// fetch_controller_if
//   Bundles the PC, instruction-memory, redirect and decode-side signals of
//   the fetch controller.
//   master : the fetch controller itself (drives PC control, memory request,
//            fetched instruction and MISALIGN).
//   slave  : the surroundings (PC register, instruction memory, execute and
//            decode stages).
// ---------------------------------------------------------------------------
interface fetch_controller_if;
    logic [31:0] pc_in;
    logic [31:0] pc_d;
    logic        pc_mode;
    logic        pc_enable;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        jump;
    logic [31:0] jump_addr;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        misalign;

    modport master (
        input  pc_in, imem_gnt, imem_rvalid, imem_rdata, jump, jump_addr, stall,
        output pc_d, pc_mode, pc_enable, imem_req, imem_addr,
               instr_valid, instr, instr_pc, misalign
    );

    modport slave (
        output pc_in, imem_gnt, imem_rvalid, imem_rdata, jump, jump_addr, stall,
        input  pc_d, pc_mode, pc_enable, imem_req, imem_addr,
               instr_valid, instr, instr_pc, misalign
    );
endinterface

// File: rtl/fetch_controller.sv
// ---------------------------------------------------------------------------
// fetch_controller
//   Instruction fetch sequencer with one outstanding memory transaction.
//   IDLE -> REQ (request at PC_IN until granted) -> WAIT (wait for response)
//   -> VALID (hold instruction for decode until it is consumed) -> REQ ...
//   Redirects (JUMP) load the PC in the same cycle; an in-flight response
//   belonging to the old path is flushed.
//
// Ports
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : fetch_controller_if.master
//          pc_in/pc_d/pc_mode/pc_enable      - PC register control
//          imem_req/addr/gnt/rvalid/rdata    - instruction memory
//          jump/jump_addr                    - redirect from execute
//          stall                             - decode back-pressure
//          instr_valid/instr/instr_pc        - fetched instruction
//          misalign                          - rejected misaligned redirect
//
// Configuration
//   FETCH_MISALIGN_CHECK_EN : when defined, redirects whose target is not
//   word aligned are ignored and flagged on misalign for one cycle. When not
//   defined, every redirect is accepted and misalign is constant 0.
// ---------------------------------------------------------------------------
module fetch_controller (
    input  logic               clk,
    input  logic               rst,
    fetch_controller_if.master bus
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_VALID = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        flush_q, flush_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        misalign_q, misalign_d;

    logic jump_misaligned;
    logic jump_live;
    logic jump_take;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign jump_misaligned = (bus.jump_addr[1:0] != 2'b00);
`else
    assign jump_misaligned = 1'b0;
`endif

    // A redirect is only meaningful once fetching has started.
    assign jump_live = bus.jump && (state_q != S_IDLE);
    assign jump_take = jump_live && !jump_misaligned;

    // PC control is combinational so the PC updates in the commanding cycle.
    assign bus.pc_d      = bus.jump_addr;
    assign bus.pc_mode   = jump_take;
    assign bus.pc_enable = jump_take || ((state_q == S_VALID) && !bus.stall);

    // While requesting, the address follows PC_IN directly; PC_IN only moves
    // in REQ when a redirect drops the request, which restarts it anyway.
    assign bus.imem_req  = (state_q == S_REQ);
    assign bus.imem_addr = (state_q == S_REQ) ? bus.pc_in : addr_q;

    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    // Without the alignment check misalign_d is constant 0, so this is a tie-off.
    assign bus.misalign    = misalign_q;

    always_comb begin
        state_d       = state_q;
        flush_d       = flush_q;
        addr_d        = addr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        misalign_d    = jump_live && jump_misaligned;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                // Redirect without grant: staying in REQ re-requests at the
                // freshly loaded PC next cycle. With grant, the response is
                // already owed to us and must be flushed.
                if (bus.imem_gnt) begin
                    addr_d  = bus.pc_in;
                    flush_d = jump_take;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    if (flush_q || jump_take) begin
                        flush_d = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        instr_d       = bus.imem_rdata;
                        instr_pc_d    = addr_q;
                        instr_valid_d = 1'b1;
                        state_d       = S_VALID;
                    end
                end else if (jump_take) begin
                    flush_d = 1'b1;
                end
            end
            S_VALID: begin
                // A redirect overrides the stall: the held instruction is
                // on the wrong path.
                if (jump_take || !bus.stall) begin
                    instr_valid_d = 1'b0;
                    state_d       = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            flush_q       <= 1'b0;
            addr_q        <= 32'h0;
            instr_q       <= NOP;
            instr_pc_q    <= 32'h0;
            instr_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_q       <= flush_d;
            addr_q        <= addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            misalign_q    <= misalign_d;
        end
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 CLK  in  1  system clock; all state updates on rising edge.
REQ-002 RES  in  1  reset, asynchronous, active-high.
REQ-003 PC_IN  in  32  current value of the program counter register.
REQ-004 PC_D  out  32  jump address presented to the program counter.
REQ-005 PC_MODE  out  1  program counter mode: 1 = load PC_D, 0 = increment by 4.
REQ-006 PC_ENABLE  out  1  program counter enable; PC updates only when 1.
REQ-007 IMEM_REQ  out  1  instruction memory request.
REQ-008 IMEM_ADDR  out  32  instruction memory address.
REQ-009 IMEM_GNT  in  1  memory accepted request this cycle.
REQ-010 IMEM_RVALID  in  1  IMEM_RDATA valid this cycle.
REQ-011 IMEM_RDATA  in  32  fetched instruction word.
REQ-012 JUMP  in  1  redirect request from execute, single-cycle pulse.
REQ-013 JUMP_ADDR  in  32  redirect target.
REQ-014 STALL  in  1  decode not ready; holds the current instruction.
REQ-015 INSTR_VALID  out  1  INSTR/INSTR_PC hold a valid fetched instruction.
REQ-016 INSTR  out  32  fetched instruction.
REQ-017 INSTR_PC  out  32  address INSTR was fetched from.
REQ-018 MISALIGN  out  1  misaligned jump target rejected (see Configuration).

Function
REQ-019 FSM states SHALL be IDLE, REQ, WAIT and VALID, with at most one outstanding memory transaction.
REQ-020 IDLE SHALL last exactly one cycle after RES deasserts, then go to REQ.
REQ-021 In REQ: IMEM_REQ=1, IMEM_ADDR=PC_IN, both held stable until IMEM_GNT=1; on IMEM_GNT go to WAIT and register the address.
REQ-022 In WAIT: on IMEM_RVALID, register IMEM_RDATA into INSTR and the registered address into INSTR_PC, then go to VALID; INSTR_VALID=1 from the next cycle.
REQ-023 In VALID with STALL=1: INSTR, INSTR_PC and INSTR_VALID held unchanged and PC_ENABLE=0.
REQ-024 In VALID with STALL=0 and JUMP=0: PC_ENABLE=1 and PC_MODE=0 for that cycle; next state REQ; INSTR_VALID=0 next cycle.
REQ-025 JUMP=1 in REQ, WAIT or VALID: PC_ENABLE=1, PC_MODE=1 and PC_D=JUMP_ADDR combinationally in the same cycle. JUMP takes priority over the increment in REQ-024.
REQ-026 JUMP in REQ without IMEM_GNT: the request is dropped and REQ is re-entered next cycle with the new PC.
REQ-027 JUMP in REQ with IMEM_GNT, or in WAIT: a flush flag is set. The pending response is discarded on IMEM_RVALID (INSTR/INSTR_VALID unchanged), then REQ is entered and the flag cleared.
REQ-028 JUMP in VALID: INSTR_VALID=0 next cycle; next state REQ regardless of STALL.
REQ-029 JUMP in the same cycle as IMEM_RVALID in WAIT: the response is discarded.
REQ-030 JUMP in IDLE SHALL be ignored.
REQ-031 PC_D SHALL equal JUMP_ADDR in all cycles; PC_ENABLE=0 and PC_MODE=0 whenever no update is commanded.

Reset
REQ-032 RES=1 SHALL immediately force state IDLE, flush flag 0, IMEM_REQ=0, IMEM_ADDR=0, PC_ENABLE=0, PC_MODE=0, INSTR_VALID=0, INSTR=0x0000_0013 (NOP), INSTR_PC=0, MISALIGN=0.
REQ-033 RES asserted mid-transaction SHALL abandon it; a late IMEM_RVALID arriving in IDLE is ignored.

Configuration
REQ-034 With FETCH_MISALIGN_CHECK_EN defined, a JUMP with JUMP_ADDR[1:0]!=0 SHALL NOT be forwarded to the PC: PC_ENABLE=0, no flush, fetch continues unaffected, and MISALIGN pulses 1 in the following cycle.
REQ-035 Without FETCH_MISALIGN_CHECK_EN, every JUMP SHALL be accepted per REQ-025, and MISALIGN SHALL be tied to 0.

Verification
REQ-036 Reset release with PC_IN=0x1A00_0000, GNT and RVALID each returned one cycle after the request, RDATA=0x0000_0093, STALL=0 -> IMEM_ADDR=0x1A00_0000, INSTR_VALID with INSTR=0x0000_0093 and INSTR_PC=0x1A00_0000, then exactly one PC_ENABLE=1/PC_MODE=0 cycle.
REQ-037 STALL=1 for 5 cycles in VALID -> INSTR unchanged, PC_ENABLE=0 throughout, no IMEM_REQ; STALL=0 -> increment, then next request at PC_IN+4.
REQ-038 JUMP to 0x1A00_0100 in WAIT -> same-cycle PC_ENABLE=1/PC_MODE=1/PC_D=0x1A00_0100; the pending RDATA is discarded with no INSTR_VALID; the next IMEM_ADDR=0x1A00_0100.
REQ-039 JUMP with GNT withheld in REQ -> no flush, next-cycle request at the new PC; JUMP+STALL in VALID -> INSTR_VALID drops, refetch.
REQ-040 With the macro, JUMP_ADDR=0x1A00_0102 -> PC_ENABLE=0, MISALIGN=1 for one cycle, fetch continues at the old PC; without the macro -> PC loads 0x1A00_0102 and MISALIGN stays 0.
REQ-041 RES pulse while in WAIT, then RVALID=1 during IDLE -> all outputs at reset values, no INSTR_VALID, fetch restarts at PC_IN.
